// File: rtl/cpu32_pkg.sv
// Shared definitions for the cpu_32_bit core: field positions, opcodes, ALU operations.
package cpu32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned IMM_W  = 17;

    // Instruction field bit positions
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 27;
    localparam int unsigned DST_MSB  = 26;
    localparam int unsigned DST_LSB  = 22;
    localparam int unsigned SRC1_MSB = 21;
    localparam int unsigned SRC1_LSB = 17;
    localparam int unsigned SRC2_MSB = 16;
    localparam int unsigned SRC2_LSB = 12;
    localparam int unsigned IMM_MSB  = 16;
    localparam int unsigned JMP_MSB  = 14;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OP_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SLL  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SRL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SLT  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01000;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01001;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01010;
    localparam logic [OP_W-1:0] OP_LW   = 5'b01011;
    localparam logic [OP_W-1:0] OP_SW   = 5'b01100;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'b01101;
    localparam logic [OP_W-1:0] OP_BNE  = 5'b01110;
    localparam logic [OP_W-1:0] OP_JMP  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SLT,
        ALU_MUL
    } alu_op_e;

endpackage

// File: rtl/cpu32_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port, R0 reads zero.
module cpu32_regfile
    import cpu32_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RIDX_W-1:0] raddr1_i,
    input  logic [RIDX_W-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    logic [XLEN-1:0] regs [0:NREGS-1];

    // Synchronous clear on reset; writes to R0 are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs[raddr2_i];

endmodule

// File: rtl/cpu_32_bit.sv
// Single-cycle 32-bit load/store core: inline decode, ALU and PC logic around cpu32_regfile.
// Optional feature macro: CPU32_MUL_EN enables opcode 10000 (MUL); otherwise it is a NOP.
module cpu_32_bit
    import cpu32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] mem_data_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] mem_addr_out,
    output logic [XLEN-1:0] mem_data_out,
    output logic            mem_we,
    output logic            mem_re,
    output logic            cpu_halted
);

    logic [OP_W-1:0]   opcode;
    logic [RIDX_W-1:0] dst_reg, src1_reg, src2_reg, rd2_addr;
    logic [IMM_W-1:0]  imm;
    logic [XLEN-1:0]   imm_sext, imm_zext;
    logic [XLEN-1:0]   rs1_val, rs2_val, alu_b, alu_res, wb_data;
    alu_op_e           alu_op;
    logic              use_imm, zext_imm, rd2_dst, wr_en;
    logic              is_lw, is_sw, is_beq, is_bne, is_jmp, is_halt;
    logic              active, do_regwr, br_taken;
    logic [XLEN-1:0]   pc_q, pc_d, pc_plus4, br_target, jmp_target;
    logic              halted_q, halted_d;

    assign opcode   = instr[OP_MSB:OP_LSB];
    assign dst_reg  = instr[DST_MSB:DST_LSB];
    assign src1_reg = instr[SRC1_MSB:SRC1_LSB];
    assign src2_reg = instr[SRC2_MSB:SRC2_LSB];
    assign imm      = instr[IMM_MSB:0];
    assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = XLEN'(imm);

    // Decode opcode into datapath controls; unlisted opcodes fall through as NOP
    always_comb begin
        alu_op   = ALU_ADD;
        use_imm  = 1'b0;
        zext_imm = 1'b0;
        rd2_dst  = 1'b0;
        wr_en    = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_jmp   = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_op = ALU_ADD; wr_en = 1'b1; end
            OP_SUB:  begin alu_op = ALU_SUB; wr_en = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND; wr_en = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;  wr_en = 1'b1; end
            OP_XOR:  begin alu_op = ALU_XOR; wr_en = 1'b1; end
            OP_SLL:  begin alu_op = ALU_SLL; wr_en = 1'b1; end
            OP_SRL:  begin alu_op = ALU_SRL; wr_en = 1'b1; end
            OP_SLT:  begin alu_op = ALU_SLT; wr_en = 1'b1; end
            OP_ADDI: begin use_imm = 1'b1; wr_en = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; zext_imm = 1'b1; wr_en = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; zext_imm = 1'b1; wr_en = 1'b1; end
            OP_LW:   begin use_imm = 1'b1; is_lw = 1'b1; wr_en = 1'b1; end
            OP_SW:   begin use_imm = 1'b1; is_sw = 1'b1; rd2_dst = 1'b1; end
            OP_BEQ:  begin is_beq = 1'b1; rd2_dst = 1'b1; end
            OP_BNE:  begin is_bne = 1'b1; rd2_dst = 1'b1; end
            OP_JMP:  begin is_jmp = 1'b1; end
            OP_MUL:  begin
`ifdef CPU32_MUL_EN
                alu_op = ALU_MUL;
                wr_en  = 1'b1;
`endif
            end
            OP_HALT: begin is_halt = 1'b1; end
            default: begin end
        endcase
    end

    // Stores and branches read R[dst] through the second port
    assign rd2_addr = rd2_dst ? dst_reg : src2_reg;

    cpu32_regfile REGS (
        .clk_i    (clk),
        .rst_i    (rst),
        .raddr1_i (src1_reg),
        .raddr2_i (rd2_addr),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val),
        .we_i     (do_regwr),
        .waddr_i  (dst_reg),
        .wdata_i  (wb_data)
    );

    assign alu_b = use_imm ? (zext_imm ? imm_zext : imm_sext) : rs2_val;

    // ALU; also forms the LW/SW effective address
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = rs1_val + alu_b;
            ALU_SUB: alu_res = rs1_val - alu_b;
            ALU_AND: alu_res = rs1_val & alu_b;
            ALU_OR:  alu_res = rs1_val | alu_b;
            ALU_XOR: alu_res = rs1_val ^ alu_b;
            ALU_SLL: alu_res = rs1_val << alu_b[4:0];
            ALU_SRL: alu_res = rs1_val >> alu_b[4:0];
            ALU_SLT: alu_res = 32'($signed(rs1_val) < $signed(alu_b));
`ifdef CPU32_MUL_EN
            ALU_MUL: alu_res = rs1_val * alu_b;
`endif
            default: alu_res = '0;
        endcase
    end

    // Nothing commits during reset or after HALT
    assign active   = !rst && !halted_q;
    assign wb_data  = is_lw ? mem_data_in : alu_res;
    assign do_regwr = active && wr_en && (dst_reg != '0);

    assign mem_we       = active && is_sw;
    assign mem_re       = active && is_lw;
    assign mem_addr_out = (is_lw || is_sw) ? alu_res : '0;
    assign mem_data_out = is_sw ? rs2_val : '0;

    assign br_taken   = (is_beq && (rs2_val == rs1_val)) || (is_bne && (rs2_val != rs1_val));
    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = pc_plus4 + {imm_sext[XLEN-3:0], 2'b00};
    assign jmp_target = XLEN'({imm[JMP_MSB:0], 2'b00});

    // Next PC and halt selection
    always_comb begin
        pc_d     = pc_plus4;
        halted_d = halted_q;
        if (is_halt) begin
            pc_d     = pc_q;
            halted_d = 1'b1;
        end else if (is_jmp) begin
            pc_d = jmp_target;
        end else if (br_taken) begin
            pc_d = br_target;
        end
    end

    // PC and halt state; frozen once halted until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign pc_out     = pc_q;
    assign cpu_halted = halted_q;

endmodule

// File: tb/tb_cpu_32_bit.sv
// Scoreboard bench for cpu_32_bit: an ISA-level model queues per-instruction expectations,
// a monitor compares them against the core each cycle, then final state is compared.
module tb_cpu_32_bit;

    typedef struct packed {
        logic [31:0] pc;
        logic        wr;
        logic [4:0]  dst;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] sdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr, mem_data_in, pc_out, mem_addr_out, mem_data_out;
    logic        mem_we, mem_re, cpu_halted;

    logic [31:0] imem      [0:63];
    logic [31:0] dmem      [0:63];
    logic [31:0] dmem_seed [0:63];
    logic        dmem_init = 1'b0;
    logic        mon_en    = 1'b0;

    logic [31:0] m_regs [0:31];
    logic [31:0] m_dmem [0:63];
    logic [31:0] m_pc;
    logic        m_halted;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] HALT_W = 32'hF800_0000;

    cpu_32_bit dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_data_in  (mem_data_in),
        .pc_out       (pc_out),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .cpu_halted   (cpu_halted)
    );

    always #5 clk = ~clk;

    assign instr       = imem[pc_out[7:2]];
    assign mem_data_in = dmem[mem_addr_out[7:2]];

    always @(posedge clk) begin
        if (dmem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= dmem_seed[i];
        end else if (mem_we) begin
            dmem[mem_addr_out[7:2]] <= mem_data_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int op, input int d, input int s1, input int s2);
        return {5'(op), 5'(d), 5'(s1), 5'(s2), 12'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int d, input int s1, input int imm);
        return {5'(op), 5'(d), 5'(s1), 17'(imm)};
    endfunction

    // One instruction at ISA level: returns what the core should present this cycle
    task automatic model_step(output exp_t e);
        logic [31:0] w, a, b, d, si, zi, res, nxt;
        logic [4:0]  op, rd;
        logic        wr;
        w   = imem[m_pc[7:2]];
        op  = w[31:27];
        rd  = w[26:22];
        a   = m_regs[w[21:17]];
        b   = m_regs[w[16:12]];
        d   = m_regs[rd];
        si  = {{15{w[16]}}, w[16:0]};
        zi  = {15'd0, w[16:0]};
        e   = '0;
        e.pc = m_pc;
        wr  = 1'b0;
        res = 32'd0;
        nxt = m_pc + 32'd4;
        case (op)
            5'd0:  begin res = a + b; wr = 1'b1; end
            5'd1:  begin res = a - b; wr = 1'b1; end
            5'd2:  begin res = a & b; wr = 1'b1; end
            5'd3:  begin res = a | b; wr = 1'b1; end
            5'd4:  begin res = a ^ b; wr = 1'b1; end
            5'd5:  begin res = a << b[4:0]; wr = 1'b1; end
            5'd6:  begin res = a >> b[4:0]; wr = 1'b1; end
            5'd7:  begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1; end
            5'd8:  begin res = a + si; wr = 1'b1; end
            5'd9:  begin res = a & zi; wr = 1'b1; end
            5'd10: begin res = a | zi; wr = 1'b1; end
            5'd11: begin
                e.re = 1'b1; e.addr = a + si; res = m_dmem[e.addr[7:2]]; wr = 1'b1;
            end
            5'd12: begin
                e.we = 1'b1; e.addr = a + si; e.sdata = d; m_dmem[e.addr[7:2]] = d;
            end
            5'd13: if (d == a) nxt = m_pc + 32'd4 + (si << 2);
            5'd14: if (d != a) nxt = m_pc + 32'd4 + (si << 2);
            5'd15: nxt = {15'd0, w[14:0], 2'b00};
`ifdef CPU32_MUL_EN
            5'd16: begin res = a * b; wr = 1'b1; end
`endif
            5'd31: begin m_halted = 1'b1; nxt = m_pc; end
            default: begin end
        endcase
        e.wr    = wr && (rd != 5'd0);
        e.dst   = rd;
        e.wdata = res;
        if (e.wr) m_regs[rd] = res;
        m_pc = nxt;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && !cpu_halted) begin
                check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("pc@%08h", e.pc), pc_out, e.pc);
                    check($sformatf("regwr@%08h", e.pc),
                          32'(dut.do_regwr && (dut.dst_reg != 5'd0)), 32'(e.wr));
                    if (e.wr) begin
                        check($sformatf("dst@%08h", e.pc), 32'(dut.dst_reg), 32'(e.dst));
                        check($sformatf("wb@%08h", e.pc), dut.wb_data, e.wdata);
                    end
                    check($sformatf("we@%08h", e.pc), 32'(mem_we), 32'(e.we));
                    check($sformatf("re@%08h", e.pc), 32'(mem_re), 32'(e.re));
                    check($sformatf("addr@%08h", e.pc), mem_addr_out, e.addr);
                    check($sformatf("sdata@%08h", e.pc), mem_data_out, e.sdata);
                end
            end
        end
    endtask

    // Two reset edges, reloading data memory; checks the held-reset state
    task automatic do_reset();
        rst = 1'b1;
        mon_en = 1'b0;
        dmem_init = 1'b1;
        @(posedge clk); #1;
        dmem_init = 1'b0;
        @(posedge clk); #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_halted", 32'(cpu_halted), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_re", 32'(mem_re), 32'd0);
    endtask

    // Queue expectations for ncyc cycles, release reset and let the core run
    task automatic run_prog(input int ncyc);
        exp_t e;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 64; i++) m_dmem[i] = dmem_seed[i];
        m_pc = 32'd0;
        m_halted = 1'b0;
        exp_q.delete();
        for (int i = 0; i < ncyc && !m_halted; i++) begin
            model_step(e);
            exp_q.push_back(e);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    task automatic end_checks();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("pc_final", pc_out, m_pc);
        check("halted_final", 32'(cpu_halted), 32'(m_halted));
        for (int r = 0; r < 32; r++) check($sformatf("reg%0d", r), dut.REGS.regs[r], m_regs[r]);
        for (int w = 0; w < 64; w++) check($sformatf("dmem%0d", w), dmem[w], m_dmem[w]);
        if (m_halted) begin
            check("halted_we", 32'(mem_we), 32'd0);
            check("halted_re", 32'(mem_re), 32'd0);
        end
    endtask

    task automatic check_regs_zero(input string tag);
        for (int r = 0; r < 32; r++) check($sformatf("%s_reg%0d", tag, r), dut.REGS.regs[r], 32'd0);
    endtask

    task automatic seed_dmem();
        for (int i = 0; i < 64; i++) dmem_seed[i] = $urandom | 32'd1;
    endtask

    task automatic load_prog1();
        for (int i = 0; i < 64; i++) imem[i] = HALT_W;
        imem[0]  = enc_i(8, 1, 0, 10);
        imem[1]  = enc_i(8, 2, 0, 20);
        imem[2]  = enc_r(0, 3, 1, 2);
        imem[3]  = enc_r(1, 4, 2, 1);
        imem[4]  = enc_r(2, 5, 1, 2);
        imem[5]  = enc_r(3, 6, 1, 2);
        imem[6]  = enc_r(4, 7, 1, 2);
        imem[7]  = enc_i(12, 0, 0, 0);
        imem[8]  = enc_i(12, 0, 0, 4);
        imem[9]  = enc_i(11, 1, 0, 0);
        imem[10] = HALT_W;
    endtask

    task automatic load_prog2();
        for (int i = 0; i < 64; i++) imem[i] = HALT_W;
        imem[0]  = enc_i(8, 0, 0, 5);
        imem[1]  = enc_i(13, 0, 0, 1);
        imem[2]  = enc_i(8, 1, 0, 99);
        imem[3]  = enc_i(15, 0, 0, 5);
        imem[4]  = enc_i(8, 2, 0, 55);
        imem[5]  = enc_i(14, 0, 0, 1);
        imem[6]  = enc_i(8, 3, 0, 7);
        imem[7]  = enc_i(8, 4, 0, 7);
        imem[8]  = enc_i(8, 5, 0, 6);
        imem[9]  = enc_r(16, 6, 4, 5);
        imem[10] = HALT_W;
    endtask

    task automatic load_rand();
        int sel, d, s1, s2;
        for (int i = 0; i < 64; i++) begin
            sel = $urandom_range(0, 19);
            d   = $urandom_range(0, 7);
            s1  = $urandom_range(0, 7);
            s2  = $urandom_range(0, 7);
            if (i < 8) imem[i] = enc_i(8, i, 0, int'($urandom));
            else if (sel <= 7 || sel == 16) imem[i] = enc_r(sel, d, s1, s2);
            else if (sel <= 10) imem[i] = enc_i(sel, d, s1, int'($urandom));
            else if (sel <= 12) imem[i] = enc_i(sel, d, s1, int'($urandom_range(0, 255)));
            else if (sel <= 14) imem[i] = enc_i(sel, d, s1, int'($urandom_range(0, 6)) - 3);
            else if (sel == 15) imem[i] = enc_i(15, 0, 0, int'($urandom_range(0, 63)));
            else if (sel == 17) imem[i] = {5'b10101, 27'($urandom)};
            else if ($urandom_range(0, 3) == 0) imem[i] = HALT_W;
            else imem[i] = enc_i(8, d, s1, int'($urandom));
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Arithmetic/logic, store/load, halt
        load_prog1();
        seed_dmem();
        do_reset();
        run_prog(12);
        end_checks();
        check("p1_halted_by_12", 32'(cpu_halted), 32'd1);
        check("p1_pc_frozen", pc_out, 32'h28);
        check("p1_r1", dut.REGS.regs[1], 32'h0);
        check("p1_r3", dut.REGS.regs[3], 32'h1E);
        check("p1_r4", dut.REGS.regs[4], 32'h0A);
        check("p1_r5", dut.REGS.regs[5], 32'h00);
        check("p1_r6", dut.REGS.regs[6], 32'h1E);
        check("p1_r7", dut.REGS.regs[7], 32'h1E);
        check("p1_mem0", dmem[0], 32'h0);
        check("p1_mem1", dmem[1], 32'h0);

        // One-cycle reset while halted
        rst = 1'b1;
        @(posedge clk); #1;
        check("hrst_pc", pc_out, 32'h0);
        check("hrst_halted", 32'(cpu_halted), 32'd0);
        check_regs_zero("hrst");

        // One-cycle reset mid-program, on top of a store
        do_reset();
        run_prog(7);
        end_checks();
        check("mid_at_sw", pc_out, 32'h1C);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_we", 32'(mem_we), 32'd0);
        check("mrst_re", 32'(mem_re), 32'd0);
        @(posedge clk); #1;
        check("mrst_pc", pc_out, 32'h0);
        check("mrst_halted", 32'(cpu_halted), 32'd0);
        check_regs_zero("mrst");

        // Branches, jump, R0 write, optional MUL
        rst = 1'b1;
        load_prog2();
        seed_dmem();
        do_reset();
        run_prog(16);
        end_checks();
        check("p2_r0", dut.REGS.regs[0], 32'h0);
        check("p2_beq_skip", dut.REGS.regs[1], 32'h0);
        check("p2_jmp_skip", dut.REGS.regs[2], 32'h0);
        check("p2_r3", dut.REGS.regs[3], 32'h7);
`ifdef CPU32_MUL_EN
        check("p2_mul", dut.REGS.regs[6], 32'd42);
`else
        check("p2_mul_nop", dut.REGS.regs[6], 32'd0);
`endif
        check("p2_pc_frozen", pc_out, 32'h28);

        // Random programs against the model
        for (int t = 0; t < 8; t++) begin
            rst = 1'b1;
            load_rand();
            seed_dmem();
            do_reset();
            run_prog(80);
            end_checks();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
